// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared types and helpers for the store read-modify-write unit
//
// Purpose: size encodings, the sequencer state type and the byte-count helper
// used by store_rmw_unit and its bench.
// Ports: none (package).
package store_pkg;

  localparam logic [2:0] SZ_BYTE  = 3'b000;
  localparam logic [2:0] SZ_HALF  = 3'b001;
  localparam logic [2:0] SZ_WORD  = 3'b010;
  localparam logic [2:0] SZ_DWORD = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_WR0  = 3'd2,
    S_RD1  = 3'd3,
    S_WR1  = 3'd4
  } state_t;

  // Byte count of a store. A dword on a 4-byte RAM collapses to a word, and
  // undefined encodings are treated as a word as well.
  function automatic logic [3:0] size_bytes(input logic [2:0] size, input int word_bytes);
    logic [3:0] nb;
    case (size)
      SZ_BYTE:  nb = 4'd1;
      SZ_HALF:  nb = 4'd2;
      SZ_DWORD: nb = (word_bytes == 8) ? 4'd8 : 4'd4;
      default:  nb = 4'd4;
    endcase
    return nb;
  endfunction

endpackage

// File: rtl/store_rmw_unit_if.sv
// rtl/store_rmw_unit_if.sv - request and RAM port bundle of the store unit
//
// Purpose: groups the store request handshake, the RAM port and the status
// pulses of store_rmw_unit.
// Modports:
//   master - requester/RAM side: drives req_valid/req_addr/req_size/req_data
//            and mem_rdata; observes everything else.
//   slave  - store_rmw_unit: drives req_ready, mem_addr, mem_re, mem_we,
//            mem_wdata, done, misalign_err.
interface store_rmw_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int OFF = $clog2(DATA_WIDTH / 8);

  logic                      req_valid;
  logic                      req_ready;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [2:0]                req_size;
  logic [DATA_WIDTH-1:0]     req_data;
  logic [ADDR_WIDTH-OFF-1:0] mem_addr;
  logic                      mem_re;
  logic [DATA_WIDTH-1:0]     mem_rdata;
  logic                      mem_we;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic                      done;
  logic                      misalign_err;

  modport master (
    output req_valid, req_addr, req_size, req_data, mem_rdata,
    input  req_ready, mem_addr, mem_re, mem_we, mem_wdata, done, misalign_err
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_data, mem_rdata,
    output req_ready, mem_addr, mem_re, mem_we, mem_wdata, done, misalign_err
  );

endinterface

// File: rtl/store_lane_merge.sv
// rtl/store_lane_merge.sv - combinational byte-lane merge of store data into a RAM word
//
// Purpose: replaces lane_count byte lanes of old_word starting at first_lane
// with store_data bytes starting at data_off.
// Ports:
//   old_word   in  DATA_WIDTH  word read back from the RAM
//   store_data in  DATA_WIDTH  LSB-aligned store data
//   first_lane in  4           first RAM byte lane to replace
//   lane_count in  4           number of lanes to replace
//   data_off   in  4           store_data byte feeding first_lane
//   merged     out DATA_WIDTH  resulting word
module store_lane_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] old_word,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [3:0]            first_lane,
  input  logic [3:0]            lane_count,
  input  logic [3:0]            data_off,
  output logic [DATA_WIDTH-1:0] merged
);
  localparam int NB = DATA_WIDTH / 8;

  always_comb begin
    merged = old_word;
    for (int i = 0; i < NB; i++) begin
      if (i >= int'(first_lane) && i < int'(first_lane) + int'(lane_count)) begin
        merged[i*8 +: 8] = store_data[(i - int'(first_lane) + int'(data_off))*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/store_rmw_unit.sv
// rtl/store_rmw_unit.sv - sequencing byte/half/word/dword store unit with RAM read-modify-write
//
// Purpose: accepts one store per handshake; partial stores are merged into a
// read-back RAM word, full aligned stores are written directly. With
// STORE_MISALIGN_EN defined, a store crossing a word boundary is split into
// two read-modify-write passes; without it such a store is accepted, no RAM
// access is made and misalign_err pulses.
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of store_rmw_unit_if (request handshake, RAM port,
//          done / misalign_err pulses)
module store_rmw_unit
  import store_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic             clk,
  input logic             rst_n,
  store_rmw_unit_if.slave bus
);
  localparam int         NB  = DATA_WIDTH / 8;
  localparam int         OFF = $clog2(NB);
  localparam int         WA  = ADDR_WIDTH - OFF;
  localparam logic [4:0] NB5 = 5'(NB);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [3:0]            nb_q;

  // Request-side decode, used only on the accept edge.
  logic           accept;
  logic           req_full;
  logic [3:0]     req_nb;
  logic [OFF-1:0] req_off;

  assign accept   = bus.req_valid && (state_q == S_IDLE);
  assign req_nb   = size_bytes(bus.req_size, NB);
  assign req_off  = bus.req_addr[OFF-1:0];
  assign req_full = (req_nb == 4'(NB)) && (req_off == '0);

  // Everything driven onto the RAM port derives from these captured values.
  logic [OFF-1:0] off_q;
  logic [WA-1:0]  word0;
  logic [4:0]     end_q;
  logic [4:0]     lim_q;

  assign off_q = addr_q[OFF-1:0];
  assign word0 = addr_q[ADDR_WIDTH-1:OFF];
  assign end_q = 5'(off_q) + 5'(nb_q);
  assign lim_q = (end_q > NB5) ? NB5 : end_q;

`ifdef STORE_MISALIGN_EN
  logic          split_q;
  logic [WA-1:0] word1;

  assign split_q = end_q > NB5;
  // Wraps to word 0 from the top of the address space.
  assign word1   = word0 + WA'(1);
  assign bus.misalign_err = 1'b0;
`else
  logic [4:0] req_end;
  logic       req_mis;
  logic       mis_err_q;

  assign req_end = 5'(req_off) + 5'(req_nb);
  assign req_mis = req_end > NB5;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_err_q <= 1'b0;
    end else begin
      mis_err_q <= accept && req_mis;
    end
  end

  assign bus.misalign_err = mis_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      nb_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= bus.req_addr;
        data_q <= bus.req_data;
        nb_q   <= req_nb;
      end
    end
  end

  logic [3:0]            m_first;
  logic [3:0]            m_count;
  logic [3:0]            m_doff;
  logic [DATA_WIDTH-1:0] merged;
  logic                  req_ready_o;
  logic                  mem_re_o;
  logic                  mem_we_o;
  logic                  done_o;
  logic [WA-1:0]         mem_addr_o;

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    done_o      = 1'b0;
    mem_addr_o  = '0;
    // First pass: lanes off..min(off+N, W)-1 from data byte 0.
    m_first     = 4'(off_q);
    m_count     = 4'(lim_q - 5'(off_q));
    m_doff      = '0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (bus.req_valid) begin
          if (req_full) begin
            state_d = S_WR0;
`ifndef STORE_MISALIGN_EN
          end else if (req_mis) begin
            state_d = S_IDLE;
`endif
          end else begin
            state_d = S_RD0;
          end
        end
      end
      S_RD0: begin
        mem_re_o   = 1'b1;
        mem_addr_o = word0;
        state_d    = S_WR0;
      end
      S_WR0: begin
        mem_we_o   = 1'b1;
        mem_addr_o = word0;
`ifdef STORE_MISALIGN_EN
        done_o     = !split_q;
        state_d    = split_q ? S_RD1 : S_IDLE;
`else
        done_o     = 1'b1;
        state_d    = S_IDLE;
`endif
      end
`ifdef STORE_MISALIGN_EN
      S_RD1: begin
        mem_re_o   = 1'b1;
        mem_addr_o = word1;
        state_d    = S_WR1;
      end
      S_WR1: begin
        mem_we_o   = 1'b1;
        mem_addr_o = word1;
        done_o     = 1'b1;
        // Second pass: the bytes that spilled past the top lane land from lane 0.
        m_first    = '0;
        m_count    = 4'(end_q - NB5);
        m_doff     = 4'(NB5 - 5'(off_q));
        state_d    = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  store_lane_merge #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_merge (
    .old_word  (bus.mem_rdata),
    .store_data(data_q),
    .first_lane(m_first),
    .lane_count(m_count),
    .data_off  (m_doff),
    .merged    (merged)
  );

  assign bus.req_ready = req_ready_o;
  assign bus.mem_re    = mem_re_o;
  assign bus.mem_we    = mem_we_o;
  assign bus.mem_addr  = mem_addr_o;
  assign bus.mem_wdata = mem_we_o ? merged : '0;
  assign bus.done      = done_o;

endmodule

// File: tb/tb_store_rmw_unit.sv
// tb/tb_store_rmw_unit.sv - self-checking bench for store_rmw_unit (DATA_WIDTH=32)
module tb_store_rmw_unit;
  import store_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
`ifdef STORE_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_rmw_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  store_rmw_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    int          cyc;
    logic        rdy, re, we, dn, er;
    logic [29:0] addr;
    logic [31:0] wdata;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          wr_count = 0;
  logic        last_ready = 1'b0;
  logic        chk_en = 1'b0;
  logic [31:0] rdata_q = '0;
  logic [31:0] ram   [logic [29:0]];
  logic [31:0] mword [logic [29:0]];
  exp_t        expq[$];

  assign bus.mem_rdata = rdata_q;

  function automatic exp_t mk(int c, logic rdy, logic re, logic we, logic [29:0] a,
                              logic [31:0] d, logic dn, logic er);
    exp_t e;
    e.cyc = c; e.rdy = rdy; e.re = re; e.we = we; e.addr = a; e.wdata = d; e.dn = dn; e.er = er;
    return e;
  endfunction

  function automatic logic [31:0] ram_word(logic [29:0] w);
    return ram.exists(w) ? ram[w] : 32'h0;
  endfunction

  function automatic logic [31:0] model_word(logic [29:0] w);
    return mword.exists(w) ? mword[w] : 32'h0;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic preload(input logic [29:0] w, input logic [31:0] v);
    ram[w]   = v;
    mword[w] = v;
  endtask

  // Byte-addressed model: apply the store byte by byte, then derive the RAM
  // traffic each cycle must show from the documented timing.
  task automatic model_store(input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] data, input int a);
    int          nb;
    logic [1:0]  off;
    logic        mis, full;
    logic [29:0] w0, w1;
    logic [31:0] ba, tmp;
    nb   = (size == SZ_BYTE) ? 1 : (size == SZ_HALF) ? 2 : 4;
    off  = addr[1:0];
    mis  = (int'(off) + nb) > 4;
    full = (nb == 4) && (off == 2'd0);
    w0   = addr[31:2];
    w1   = w0 + 30'd1;
    if (mis && !MIS_EN) begin
      expq.push_back(mk(a, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1));
      return;
    end
    for (int j = 0; j < nb; j++) begin
      ba  = addr + 32'(j);
      tmp = model_word(ba[31:2]);
      tmp[int'(ba[1:0])*8 +: 8] = data[j*8 +: 8];
      mword[ba[31:2]] = tmp;
    end
    if (full) begin
      expq.push_back(mk(a, 1'b0, 1'b0, 1'b1, w0, model_word(w0), 1'b1, 1'b0));
    end else begin
      expq.push_back(mk(a,     1'b0, 1'b1, 1'b0, w0, '0, 1'b0, 1'b0));
      expq.push_back(mk(a + 1, 1'b0, 1'b0, 1'b1, w0, model_word(w0), !mis, 1'b0));
      if (mis) begin
        expq.push_back(mk(a + 2, 1'b0, 1'b1, 1'b0, w1, '0, 1'b0, 1'b0));
        expq.push_back(mk(a + 3, 1'b0, 1'b0, 1'b1, w1, model_word(w1), 1'b1, 1'b0));
      end
    end
  endtask

  task ram_proc();
    forever begin
      @(posedge clk);
      cyc        <= cyc + 1;
      last_ready <= bus.req_ready;
      if (bus.mem_re) rdata_q <= ram_word(bus.mem_addr);
      if (bus.mem_we) begin
        ram[bus.mem_addr] = bus.mem_wdata;
        wr_count <= wr_count + 1;
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e = mk(cyc, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        if (expq.size() > 0 && expq[0].cyc == cyc) e = expq.pop_front();
        total++;
        if ({bus.req_ready, bus.mem_re, bus.mem_we, bus.done, bus.misalign_err, bus.mem_addr, bus.mem_wdata}
            !== {e.rdy, e.re, e.we, e.dn, e.er, e.addr, e.wdata}) begin
          bad++;
          $display("FAIL cyc%0d outputs: got rdy=%b re=%b we=%b done=%b err=%b addr=%h wdata=%h want rdy=%b re=%b we=%b done=%b err=%b addr=%h wdata=%h",
                   cyc, bus.req_ready, bus.mem_re, bus.mem_we, bus.done, bus.misalign_err, bus.mem_addr,
                   bus.mem_wdata, e.rdy, e.re, e.we, e.dn, e.er, e.addr, e.wdata);
        end
      end
    end
  endtask

  task automatic issue(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    logic ok;
    ok = 1'b0;
    bus.req_addr  = addr;
    bus.req_size  = size;
    bus.req_data  = data;
    bus.req_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (last_ready) begin
        ok = 1'b1;
        break;
      end
    end
    bus.req_valid = 1'b0;
    check("accept", 64'(ok), 64'd1);
    if (ok) model_store(addr, size, data, cyc);
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (expq.size() == 0 && bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", 64'(ok), 64'd1);
  endtask

  initial begin
    int wc0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_size  = '0;
    bus.req_data  = '0;
    fork
      ram_proc();
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(bus.req_ready), 64'd1);
    check("rst_strobes", 64'({bus.mem_re, bus.mem_we, bus.done, bus.misalign_err}), 64'd0);
    check("rst_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    preload(30'h10, 32'h11223344);
    preload(30'h40, 32'h00000000);
    preload(30'h41, 32'hFFFFFFFF);
    preload(30'h81, 32'hCAFEF00D);
    preload(30'h90, 32'hFFFFFFFF);
    preload(30'hC0, 32'h55555555);
    preload(30'hC1, 32'h66666666);
    preload(30'h3FFFFFFF, 32'h01020304);
    preload(30'h0, 32'h0A0B0C0D);

    issue(32'h42, SZ_BYTE, 32'hAB);
    issue(32'h200, SZ_WORD, 32'hDEADBEEF);
    issue(32'h103, SZ_HALF, 32'hBEEF);
    issue(32'h206, SZ_HALF, 32'h1234);
    for (int k = 0; k < 4; k++) issue(32'h240 + 32'(k), SZ_BYTE, 32'h10 + 32'(k));
    issue(32'h301, SZ_WORD, 32'hA1B2C3D4);
    issue(32'hFFFFFFFF, SZ_HALF, 32'h9988);
    issue(32'h400, SZ_DWORD, 32'h55667788);
    drain();

    check("ram_sb", 64'(ram_word(30'h10)), 64'h11AB3344);
    check("ram_sw", 64'(ram_word(30'h80)), 64'hDEADBEEF);
    check("ram_sh_split0", 64'(ram_word(30'h40)), MIS_EN ? 64'hEF000000 : 64'h00000000);
    check("ram_sh_split1", 64'(ram_word(30'h41)), MIS_EN ? 64'hFFFFFFBE : 64'hFFFFFFFF);
    check("ram_sh_aligned", 64'(ram_word(30'h81)), 64'h1234F00D);
    check("ram_sb_lanes", 64'(ram_word(30'h90)), 64'h13121110);
    check("ram_sw_split0", 64'(ram_word(30'hC0)), MIS_EN ? 64'hB2C3D455 : 64'h55555555);
    check("ram_sw_split1", 64'(ram_word(30'hC1)), MIS_EN ? 64'h666666A1 : 64'h66666666);
    check("ram_wrap_top", 64'(ram_word(30'h3FFFFFFF)), MIS_EN ? 64'h88020304 : 64'h01020304);
    check("ram_wrap_zero", 64'(ram_word(30'h0)), MIS_EN ? 64'h0A0B0C99 : 64'h0A0B0C0D);
    check("ram_sd_as_word", 64'(ram_word(30'h100)), 64'h55667788);
    check("write_count", 64'(wr_count), MIS_EN ? 64'd14 : 64'd8);

    // Reset mid-operation: strobes must drop at once and no further write may land.
    wc0 = wr_count;
`ifdef STORE_MISALIGN_EN
    preload(30'h50, 32'h00000000);
    preload(30'h51, 32'hFFFFFFFF);
    issue(32'h143, SZ_HALF, 32'hBEEF);
    repeat (3) @(negedge clk);
`else
    preload(30'h50, 32'h12345678);
    issue(32'h141, SZ_BYTE, 32'h77);
    @(negedge clk);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_strobes", 64'({bus.mem_re, bus.mem_we, bus.done, bus.misalign_err}), 64'd0);
    check("midrst_addr", 64'(bus.mem_addr), 64'd0);
    check("midrst_ready", 64'(bus.req_ready), 64'd1);
    expq.delete();
`ifdef STORE_MISALIGN_EN
    mword[30'h51] = 32'hFFFFFFFF;
`else
    mword[30'h50] = 32'h12345678;
`endif
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_word0", 64'(ram_word(30'h50)), MIS_EN ? 64'hEF000000 : 64'h12345678);
    check("midrst_word1", 64'(ram_word(30'h51)), MIS_EN ? 64'hFFFFFFFF : 64'h00000000);
    check("midrst_writes", 64'(wr_count - wc0), MIS_EN ? 64'd1 : 64'd0);

    issue(32'h42, SZ_BYTE, 32'hCD);
    drain();
    check("ram_after_rst", 64'(ram_word(30'h10)), 64'h11CD3344);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
